dpwm_multiphase: RTL
====================

Name: dpwm_multiphase

Overview:
Parametrised successor to the single-phase complementary DPWM. It generates N_PH interleaved high-side/low-side gate pairs (c1/c2) for a multiphase buck power stage, with a programmable switching period. Each phase has independent leading (dt1) and trailing (dt2) dead times. Double-buffered settings are applied glitch-free at period boundaries. It sits between the digital compensator (which supplies i_ton) and the gate drivers.

Parameters:
CNT_W, 11, width of period/on-time/counter values
DT_W, 5, width of dead-time values
N_PH, 2, number of interleaved phases; power of two, 1..8

Ports:
i_clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  run control; low forces outputs off
i_period  input  CNT_W  switching period P in clocks
i_ton  input  CNT_W  on-time in clocks (pre dead-time)
i_dt1  input  DT_W  dead time before c1 turns on
i_dt2  input  DT_W  dead time before c2 turns on
i_load  input  1  strobe: capture i_period/i_ton/i_dt1/i_dt2 into pending set
c1  output  N_PH  high-side gate per phase
c2  output  N_PH  low-side gate per phase
o_sync  output  1  one-cycle pulse at phase-0 period start
o_upd  output  1  one-cycle pulse when pending set becomes active

Behaviour:
- Reset (sync, i_clk rising edge with reset=1): pending and active sets = 0, cnt = 0, all offsets = 0. c1, c2, o_sync, o_upd = 0. Reset dominates enable and i_load.
- Pending set: on any cycle with i_load=1, it captures the inputs; there is no other path into it.
- Active set: copied from pending when cnt = P_act-1 with enable=1 (period wrap). o_upd pulses, aligned with the first output cycle of the new period. While enable=0, pending is copied to active every cycle, so a restart uses the latest values.
- Simultaneous i_load and apply: the apply uses the pending value held before that edge. The new load waits for the next boundary.
- Counter: cnt runs 0..P_act-1, wraps to 0, and only advances when enable=1. With enable=0, cnt is held at 0.
- P_act = 0: cnt held at 0, all gates low, o_sync low. P_act = 1 is treated as 2.
- Phase offset: off_k = (k*P_act) >> log2(N_PH), computed when the set becomes active. pc_k = cnt + off_k, minus P_act if the sum ≥ P_act.
- Duty clamp: ton_eff = min(ton_act, P_act).
- All comparisons are done in CNT_W+1 bits (no overflow).
- Gate decode per phase k (registered):
  - c1[k] = enable & (dt1 ≤ pc_k) & (pc_k < ton_eff)
  - c2[k] = enable & (ton_eff+dt2 ≤ pc_k) & (pc_k < P_act)
  - Empty intervals yield constant 0.
  - c1[k] and c2[k] are never simultaneously 1. This is an invariant, including across updates, because active values change only at a wrap.
- Latency: gate outputs and o_sync are registered, one cycle after the cnt/pc value they decode. o_sync = 1 in the cycle following cnt = 0 with enable=1.
- enable falling: gates and o_sync go low at the next edge and cnt goes to 0. After enable rises, cnt = 0 is decoded on the first enabled cycle.
- Reset mid-period: outputs low at next edge; settings lost; i_load is required before output resumes.

Test Plan:
1. Reset, load P=20, ton=10, dt1=2, dt2=3, enable=1, N_PH=2 -> phase 0: c1 high for pc 2..9 (8 clk), c2 high for pc 13..19 (7 clk); o_sync period 20 clk; c1&c2 never both 1.
2. Same config -> phase 1 waveform identical to phase 0, delayed by 10 clk (off_1=10). With N_PH=4 and P=20: offsets 0/5/10/15.
3. Mid-period (cnt=5) load ton=15 -> current period unchanged. Next period c1 pc 2..14, c2 pc 18..19. o_upd pulses once, coincident with o_sync.
4. Clamp/empty cases:
   - ton=25, P=20 -> c1 pc 2..19, c2 never.
   - ton=2, dt1=2 -> c1 never.
   - ton=18, dt2=3 -> c2 never.
   - P=0 -> all gates low.
5. enable dropped at cnt=7 -> gates low next edge. Re-enable after loading P=30 -> first period 30 clk from cnt 0, new values without a load boundary.
6. Reset asserted mid-c1 pulse, and i_load coincident with the wrap -> all outputs 0 next edge. Coincident load applied one period later.

Source files
------------

// File: rtl/dpwm_multiphase.sv
// dpwm_multiphase: N_PH interleaved complementary gate pairs for a multiphase buck.
// Each phase k is the same waveform, shifted by off_k = (k*P) >> log2(N_PH) clocks.
// Settings are double-buffered: i_load fills a pending set that becomes active
// at a period wrap, or on every cycle while enable is low.
//
// Ports:
//   i_clk     system clock
//   reset     synchronous active-high reset
//   enable    run control; low forces all gates off and holds cnt at 0
//   i_period  switching period P in clocks (1 behaves as 2, 0 stops switching)
//   i_ton     on-time in clocks before dead time, clamped to P
//   i_dt1     dead time before c1 turns on
//   i_dt2     dead time before c2 turns on
//   i_load    strobe capturing i_period/i_ton/i_dt1/i_dt2 into the pending set
//   c1, c2    high-side / low-side gate per phase (registered)
//   o_sync    one-cycle pulse at the phase-0 period start (registered)
//   o_upd     one-cycle pulse, with o_sync, when a newly loaded set takes effect
module dpwm_multiphase #(
  parameter int unsigned CNT_W = 11,
  parameter int unsigned DT_W  = 5,
  parameter int unsigned N_PH  = 2
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [CNT_W-1:0]  i_period,
  input  logic [CNT_W-1:0]  i_ton,
  input  logic [DT_W-1:0]   i_dt1,
  input  logic [DT_W-1:0]   i_dt2,
  input  logic              i_load,
  output logic [N_PH-1:0]   c1,
  output logic [N_PH-1:0]   c2,
  output logic              o_sync,
  output logic              o_upd
);

  localparam int unsigned SH = $clog2(N_PH);
  localparam int unsigned CW = CNT_W + 1;   // comparison width, no overflow
  localparam int unsigned OW = CNT_W + 3;   // k*P with k up to 7

  logic [CNT_W-1:0] pend_per, pend_ton;
  logic [DT_W-1:0]  pend_dt1, pend_dt2;
  logic             pend_dirty;

  logic [CNT_W-1:0] act_per, act_ton;
  logic [DT_W-1:0]  act_dt1, act_dt2;
  logic [CNT_W-1:0] act_off [N_PH];

  logic [CNT_W-1:0] cnt;
  logic             upd_flag;

  logic [CW-1:0]    per_eff, ton_eff, pend_pe;
  logic             run, wrap, apply;
  logic [CNT_W-1:0] off_new [N_PH];
  logic [CW-1:0]    pc_sum  [N_PH];
  logic [CW-1:0]    pc      [N_PH];
  logic [N_PH-1:0]  c1_nx, c2_nx;

  // Effective period/on-time and the period-boundary apply condition
  always_comb begin
    per_eff = (act_per == CNT_W'(1)) ? CW'(2) : CW'(act_per);
    ton_eff = (CW'(act_ton) < per_eff) ? CW'(act_ton) : per_eff;
    pend_pe = (pend_per == CNT_W'(1)) ? CW'(2) : CW'(pend_per);
    run     = enable & (per_eff != '0);
    wrap    = run & (CW'(cnt) == (per_eff - CW'(1)));
    apply   = ~enable | wrap;
  end

  // Phase offsets of the pending set, latched together with it on apply
  always_comb begin
    for (int k = 0; k < N_PH; k++) begin
      off_new[k] = CNT_W'((OW'(k) * OW'(pend_pe)) >> SH);
    end
  end

  // Per-phase position in the period and gate decode
  always_comb begin
    c1_nx = '0;
    c2_nx = '0;
    for (int k = 0; k < N_PH; k++) begin
      pc_sum[k] = CW'(cnt) + CW'(act_off[k]);
      pc[k]     = (pc_sum[k] >= per_eff) ? (pc_sum[k] - per_eff) : pc_sum[k];
      c1_nx[k]  = run & (CW'(act_dt1) <= pc[k]) & (pc[k] < ton_eff);
      c2_nx[k]  = run & ((ton_eff + CW'(act_dt2)) <= pc[k]) & (pc[k] < per_eff);
    end
  end

  // Settings buffers, period counter and registered outputs
  always_ff @(posedge i_clk) begin
    if (reset) begin
      pend_per   <= '0;
      pend_ton   <= '0;
      pend_dt1   <= '0;
      pend_dt2   <= '0;
      pend_dirty <= 1'b0;
      act_per    <= '0;
      act_ton    <= '0;
      act_dt1    <= '0;
      act_dt2    <= '0;
      for (int k = 0; k < N_PH; k++) act_off[k] <= '0;
      cnt        <= '0;
      upd_flag   <= 1'b0;
      c1         <= '0;
      c2         <= '0;
      o_sync     <= 1'b0;
      o_upd      <= 1'b0;
    end else begin
      if (apply) begin
        act_per <= pend_per;
        act_ton <= pend_ton;
        act_dt1 <= pend_dt1;
        act_dt2 <= pend_dt2;
        for (int k = 0; k < N_PH; k++) act_off[k] <= off_new[k];
      end
      if (i_load) begin
        pend_per <= i_period;
        pend_ton <= i_ton;
        pend_dt1 <= i_dt1;
        pend_dt2 <= i_dt2;
      end
      // A load on the apply edge stays pending for the next boundary
      pend_dirty <= i_load | (pend_dirty & ~apply);
      upd_flag   <= wrap & pend_dirty;
      cnt        <= (wrap | ~run) ? '0 : cnt + CNT_W'(1);
      c1         <= c1_nx;
      c2         <= c2_nx;
      o_sync     <= run & (cnt == '0);
      o_upd      <= upd_flag & enable;
    end
  end

endmodule
